// File: rtl/complex_div.sv
// complex_div -- sequential complex divider
//
// Computes (a+jb)/(c+jd) = ((ac+bd) + j(bc-ad)) / (c^2+d^2) with a=num_re,
// b=num_im, c=den_re, d=den_im. The products are kept at full precision and
// both quotient components are produced in parallel by unsigned restoring
// dividers, one quotient bit per cycle, then signed (truncation toward zero).
//
// Parameters:
//   FRAC_BITS  quotient is scaled by 2^FRAC_BITS (0..16)
//
// Build option:
//   CDIV_SATURATE_EN  when defined, out-of-range components clamp to
//                     +2^31-1 / -2^31 and ovf is raised; otherwise the low
//                     32 bits of the signed quotient are returned, ovf = 0.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset
//   in_valid / in_ready  operand handshake (ready only while idle)
//   num_re, num_im       numerator, two's complement
//   den_re, den_im       denominator, two's complement
//   out_valid / out_ready result handshake
//   quo_re, quo_im       quotient, two's complement
//   div_zero             denominator was 0+0j
//   ovf                  a component left the 32-bit signed range
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// MUL   | products and |numerators| formed, divider loaded
// DIV   | 64+FRAC_BITS shift-subtract iterations, last one also signs
// DONE  | result presented, held until out_ready

module complex_div #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] num_re,
    input  logic [31:0] num_im,
    input  logic [31:0] den_re,
    input  logic [31:0] den_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quo_re,
    output logic [31:0] quo_im,
    output logic        div_zero,
    output logic        ovf
);

    localparam int QW = 64 + FRAC_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic signed [31:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [QW-1:0]      dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
    logic [63:0]        rem_re_q, rem_re_d, rem_im_q, rem_im_d;
    logic [63:0]        den_q, den_d;
    logic               neg_re_q, neg_re_d, neg_im_q, neg_im_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [31:0]        quo_re_q, quo_re_d, quo_im_q, quo_im_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               last_iter;
    logic signed [63:0] p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
    logic signed [64:0] n_re, n_im;
    logic [63:0]        den_full;
    logic [63:0]        mag_re, mag_im;
    logic [64:0]        rs_re, rs_im;
    logic [63:0]        rem_re_nx, rem_im_nx;
    logic [QW-1:0]      q_re, q_im;
    logic [31:0]        fin_re, fin_im;
    logic               fin_ovf;

    assign accept    = in_valid && in_ready_q;
    assign last_iter = (cnt_q == 7'd1);

    // Full-precision products from the captured operands.
    assign p_ac = 64'(a_q) * 64'(c_q);
    assign p_bd = 64'(b_q) * 64'(d_q);
    assign p_bc = 64'(b_q) * 64'(c_q);
    assign p_ad = 64'(a_q) * 64'(d_q);
    assign p_cc = 64'(c_q) * 64'(c_q);
    assign p_dd = 64'(d_q) * 64'(d_q);

    assign n_re     = 65'(p_ac) + 65'(p_bd);
    assign n_im     = 65'(p_bc) - 65'(p_ad);
    assign den_full = $unsigned(p_cc) + $unsigned(p_dd);

    // |numerator| never exceeds 2^63, so 64 bits of magnitude suffice.
    assign mag_re = n_re[64] ? 64'(-n_re) : n_re[63:0];
    assign mag_im = n_im[64] ? 64'(-n_im) : n_im[63:0];

    // One restoring step per component; the remainder is always < den,
    // so the shifted remainder fits 65 bits and the difference fits 64.
    always_comb begin
        rs_re = {rem_re_q, dvd_re_q[QW-1]};
        rs_im = {rem_im_q, dvd_im_q[QW-1]};
        if (rs_re >= {1'b0, den_q}) begin
            rem_re_nx = rs_re[63:0] - den_q;
            q_re      = {dvd_re_q[QW-2:0], 1'b1};
        end else begin
            rem_re_nx = rs_re[63:0];
            q_re      = {dvd_re_q[QW-2:0], 1'b0};
        end
        if (rs_im >= {1'b0, den_q}) begin
            rem_im_nx = rs_im[63:0] - den_q;
            q_im      = {dvd_im_q[QW-2:0], 1'b1};
        end else begin
            rem_im_nx = rs_im[63:0];
            q_im      = {dvd_im_q[QW-2:0], 1'b0};
        end
    end

    // Sign restore (and optional clamp) applied to the quotient emerging
    // from the final iteration. Negating the low 32 bits equals the low 32
    // bits of the full negation.
    always_comb begin
        fin_re  = neg_re_q ? (~q_re[31:0] + 32'd1) : q_re[31:0];
        fin_im  = neg_im_q ? (~q_im[31:0] + 32'd1) : q_im[31:0];
        fin_ovf = 1'b0;
`ifdef CDIV_SATURATE_EN
        if (!neg_re_q && (q_re > QW'(64'h7FFF_FFFF))) begin
            fin_re  = 32'h7FFF_FFFF;
            fin_ovf = 1'b1;
        end else if (neg_re_q && (q_re > QW'(64'h8000_0000))) begin
            fin_re  = 32'h8000_0000;
            fin_ovf = 1'b1;
        end
        if (!neg_im_q && (q_im > QW'(64'h7FFF_FFFF))) begin
            fin_im  = 32'h7FFF_FFFF;
            fin_ovf = 1'b1;
        end else if (neg_im_q && (q_im > QW'(64'h8000_0000))) begin
            fin_im  = 32'h8000_0000;
            fin_ovf = 1'b1;
        end
`endif
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_MUL;
            S_MUL:  state_d = (den_full == 64'd0) ? S_DONE : S_DIV;
            S_DIV:  if (last_iter) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs. in_ready is registered so it stays low during reset
    // and rises on the first edge after release.
    always_comb begin
        in_ready_d = (state_d == S_IDLE);
        out_valid  = (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        dvd_re_d   = dvd_re_q;
        dvd_im_d   = dvd_im_q;
        rem_re_d   = rem_re_q;
        rem_im_d   = rem_im_q;
        den_d      = den_q;
        neg_re_d   = neg_re_q;
        neg_im_d   = neg_im_q;
        cnt_d      = cnt_q;
        quo_re_d   = quo_re_q;
        quo_im_d   = quo_im_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d = num_re;
                    b_d = num_im;
                    c_d = den_re;
                    d_d = den_im;
                end
            end
            S_MUL: begin
                den_d    = den_full;
                neg_re_d = n_re[64];
                neg_im_d = n_im[64];
                dvd_re_d = QW'(mag_re) << FRAC_BITS;
                dvd_im_d = QW'(mag_im) << FRAC_BITS;
                rem_re_d = 64'd0;
                rem_im_d = 64'd0;
                cnt_d    = 7'(QW);
                if (den_full == 64'd0) begin
                    quo_re_d   = 32'd0;
                    quo_im_d   = 32'd0;
                    div_zero_d = 1'b1;
                    ovf_d      = 1'b0;
                end else begin
                    div_zero_d = 1'b0;
                end
            end
            S_DIV: begin
                dvd_re_d = q_re;
                dvd_im_d = q_im;
                rem_re_d = rem_re_nx;
                rem_im_d = rem_im_nx;
                cnt_d    = cnt_q - 7'd1;
                if (last_iter) begin
                    quo_re_d = fin_re;
                    quo_im_d = fin_im;
                    ovf_d    = fin_ovf;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            dvd_re_q   <= '0;
            dvd_im_q   <= '0;
            rem_re_q   <= '0;
            rem_im_q   <= '0;
            den_q      <= '0;
            neg_re_q   <= 1'b0;
            neg_im_q   <= 1'b0;
            cnt_q      <= '0;
            quo_re_q   <= '0;
            quo_im_q   <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            dvd_re_q   <= dvd_re_d;
            dvd_im_q   <= dvd_im_d;
            rem_re_q   <= rem_re_d;
            rem_im_q   <= rem_im_d;
            den_q      <= den_d;
            neg_re_q   <= neg_re_d;
            neg_im_q   <= neg_im_d;
            cnt_q      <= cnt_d;
            quo_re_q   <= quo_re_d;
            quo_im_q   <= quo_im_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready = in_ready_q;
    assign quo_re   = quo_re_q;
    assign quo_im   = quo_im_q;
    assign div_zero = div_zero_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_complex_div.sv
module tb_complex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] num_re = '0, num_im = '0, den_re = '0, den_im = '0;
    logic        out_ready = 1'b0;

    logic        in_valid0 = 1'b0, in_valid8 = 1'b0;
    logic        in_ready0, in_ready8, out_valid0, out_valid8;
    logic [31:0] quo_re0, quo_im0, quo_re8, quo_im8;
    logic        div_zero0, div_zero8, ovf0, ovf8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    complex_div #(.FRAC_BITS(0)) u_div0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .num_re(num_re), .num_im(num_im), .den_re(den_re), .den_im(den_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .quo_re(quo_re0), .quo_im(quo_im0),
        .div_zero(div_zero0), .ovf(ovf0)
    );

    complex_div #(.FRAC_BITS(8)) u_div8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .num_re(num_re), .num_im(num_im), .den_re(den_re), .den_im(den_im),
        .out_valid(out_valid8), .out_ready(out_ready),
        .quo_re(quo_re8), .quo_im(quo_im8),
        .div_zero(div_zero8), .ovf(ovf8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? in_ready8 : in_ready0;
    endfunction

    function automatic logic vld(input bit sel);
        return sel ? out_valid8 : out_valid0;
    endfunction

    // Presents operands and returns #1 after the accepting edge.
    task automatic start(input bit sel, input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(rdy(sel)), 64'd1);
        num_re = a; num_im = b; den_re = c; den_im = d;
        if (sel) in_valid8 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid8 = 1'b0;
    endtask

    // Counts edges with the accepting edge as edge 1.
    task automatic wait_out(input bit sel, output int lat);
        lat = 1;
        while (!vld(sel) && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input bit sel, input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, ".ready_in_done"}, 64'(rdy(sel)), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".valid_after_hs"}, 64'(vld(sel)), 64'd0);
        chk({tag, ".ready_after_hs"}, 64'(rdy(sel)), 64'd1);
    endtask

    task automatic run0(input string tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic [31:0] e_re, input logic [31:0] e_im,
                        input logic e_dz, input logic e_ovf, input int e_lat);
        int lat;
        start(1'b0, tag, a, b, c, d);
        wait_out(1'b0, lat);
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".re"}, 64'(quo_re0), 64'(e_re));
        chk({tag, ".im"}, 64'(quo_im0), 64'(e_im));
        chk({tag, ".div_zero"}, 64'(div_zero0), 64'(e_dz));
        chk({tag, ".ovf"}, 64'(ovf0), 64'(e_ovf));
        handshake(1'b0, tag);
    endtask

    initial begin
        int lat;
        logic [31:0] ovf_re_exp;
        logic        ovf_flag_exp;
`ifdef CDIV_SATURATE_EN
        ovf_re_exp   = 32'h7FFF_FFFF;
        ovf_flag_exp = 1'b1;
`else
        ovf_re_exp   = 32'h8000_0000;
        ovf_flag_exp = 1'b0;
`endif

        #12;
        chk("reset.in_ready", 64'(in_ready0), 64'd0);
        chk("reset.out_valid", 64'(out_valid0), 64'd0);
        chk("reset.quo_re", 64'(quo_re0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release.in_ready", 64'(in_ready0), 64'd1);

        run0("basic",   32'd6, 32'd8, 32'd3, 32'd4, 32'd2, 32'd0, 1'b0, 1'b0, 66);
        run0("trunc_p", 32'd7, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 1'b0, 1'b0, 66);
        run0("trunc_n", 32'hFFFF_FFF9, 32'd0, 32'd2, 32'd0,
             32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, 66);
        run0("imag",    32'd0, 32'd5, 32'd0, 32'd1, 32'd5, 32'd0, 1'b0, 1'b0, 66);
        run0("dz",      32'd100, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2);
        run0("ovf",     32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd0,
             ovf_re_exp, 32'd0, 1'b0, ovf_flag_exp, 66);

        // Fixed-point output with backpressure on the FRAC_BITS=8 instance.
        start(1'b1, "fx", 32'd1, 32'd0, 32'd2, 32'd0);
        wait_out(1'b1, lat);
        chk("fx.latency", 64'(lat), 64'd74);
        chk("fx.re", 64'(quo_re8), 64'd128);
        chk("fx.im", 64'(quo_im8), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid8 = 1'b1;
            num_re = 32'd9; den_re = 32'd1;
            chk("bp.in_ready", 64'(in_ready8), 64'd0);
            @(posedge clk);
            #1;
            in_valid8 = 1'b0;
            chk("bp.valid", 64'(out_valid8), 64'd1);
            chk("bp.re", 64'(quo_re8), 64'd128);
            chk("bp.dz_ovf", 64'({div_zero8, ovf8}), 64'd0);
        end
        handshake(1'b1, "fx");

        // Reset in the middle of the divide.
        start(1'b0, "rst_mid", 32'd6, 32'd8, 32'd3, 32'd4);
        repeat (21) @(posedge clk);
        #1;
        chk("rst_mid.valid_before", 64'(out_valid0), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid.quo_re", 64'(quo_re0), 64'd0);
        chk("rst_mid.ovf", 64'(ovf0), 64'd0);
        chk("rst_mid.in_ready", 64'(in_ready0), 64'd0);
        chk("rst_mid.valid", 64'(out_valid0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.release_ready", 64'(in_ready0), 64'd1);
        run0("after_rst", 32'd6, 32'd8, 32'd3, 32'd4, 32'd2, 32'd0, 1'b0, 1'b0, 66);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
